// File: rtl/bsg_mem_nr1w_one_hot_valid_pkg.sv
// Shared helpers for the one-hot addressed register file with per-entry valid bits.
// Only width arithmetic lives here; no types are exported.
package bsg_mem_nr1w_one_hot_valid_pkg;

    // Width of a counter able to hold 0..els inclusive.
    function automatic int unsigned cnt_width(input int unsigned els);
        return (els < 1) ? 1 : $clog2(els + 1);
    endfunction

    // Number of set bits among the low n bits of v.
    // This is used when a popcount of a parameter-sized vector is needed.
    function automatic int unsigned ones_in(input logic [1023:0] v, input int unsigned n);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i < n && v[i]) begin
                acc = acc + 1;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/bsg_mem_one_hot_read_port.sv
// One read port of the one-hot register file: AND-OR mux over the entries,
// valid hit detection, optional write-to-read bypass and optional output register.
module bsg_mem_one_hot_read_port #(
    parameter int width_p        = 32,
    parameter int els_p          = 8,
    parameter int sync_read_p    = 0,
    parameter int write_bypass_p = 0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [els_p*width_p-1:0]  data_i,
    input  logic [els_p-1:0]          valid_i,
    input  logic [els_p-1:0]          r_v_i,
    input  logic [els_p-1:0]          w_v_i,
    input  logic [width_p-1:0]        w_data_i,
    output logic [width_p-1:0]        r_data_o,
    output logic                      r_valid_o
);

    logic [width_p-1:0] masked [els_p];
    logic [width_p-1:0] mux_data;
    logic               hit;
    logic               bypass_hit;
    logic [width_p-1:0] rd_data_d;
    logic               rd_valid_d;

    // Gate each entry by its select bit; a multi-hot select ORs the entries together.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_mask
        assign masked[gi] = data_i[gi*width_p +: width_p] & {width_p{r_v_i[gi]}};
    end

    // OR-reduce the gated entries into the read data.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < els_p; i++) begin
            mux_data = mux_data | masked[i];
        end
    end

    assign hit = |(r_v_i & valid_i);

    if (write_bypass_p != 0) begin : g_bypass
        assign bypass_hit = |(r_v_i & w_v_i);
    end else begin : g_no_bypass
        // Without bypass the write select is irrelevant to this port.
        logic unused_w_v;
        assign unused_w_v = ^w_v_i;
        assign bypass_hit = 1'b0;
    end

    // Same-cycle write of a selected entry overrides the stored data and valid.
    always_comb begin
        rd_data_d  = bypass_hit ? w_data_i : mux_data;
        rd_valid_d = bypass_hit | hit;
    end

    if (sync_read_p != 0) begin : g_sync
        logic [width_p-1:0] r_data_q;
        logic               r_valid_q;

        // Capture the read only when the port is selecting something; otherwise hold.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_data_q  <= '0;
                r_valid_q <= 1'b0;
            end else if (|r_v_i) begin
                r_data_q  <= rd_data_d;
                r_valid_q <= rd_valid_d;
            end
        end

        assign r_data_o  = r_data_q;
        assign r_valid_o = r_valid_q;
    end else begin : g_comb
        // Combinational port has no state, so clock and reset go unused here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ reset_n_i;
        assign r_data_o  = rd_data_d;
        assign r_valid_o = rd_valid_d;
    end

endmodule

// File: rtl/bsg_mem_nr1w_one_hot_valid.sv
// One-write, N-read register file with one-hot addressing and a valid bit per entry.
// Tracks occupancy incrementally and reports full/empty from the count register.
module bsg_mem_nr1w_one_hot_valid
    import bsg_mem_nr1w_one_hot_valid_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int els_p          = 8,
    parameter int read_ports_p   = 2,
    parameter int sync_read_p    = 0,
    parameter int write_bypass_p = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [els_p-1:0]                  w_v_i,
    input  logic [width_p-1:0]                w_data_i,
    input  logic [els_p-1:0]                  clr_v_i,
    input  logic [read_ports_p*els_p-1:0]     r_v_i,
    output logic [read_ports_p*width_p-1:0]   r_data_o,
    output logic [read_ports_p-1:0]           r_valid_o,
    output logic [els_p-1:0]                  valid_o,
    output logic [cnt_width(els_p)-1:0]       count_o,
    output logic                              full_o,
    output logic                              empty_o
);

    localparam int cnt_w_lp = cnt_width(els_p);

    logic [els_p-1:0]         valid_q;
    logic [els_p-1:0]         valid_d;
    logic [cnt_w_lp-1:0]      count_q;
    logic [cnt_w_lp-1:0]      count_d;
    logic [cnt_w_lp-1:0]      inc_cnt;
    logic [cnt_w_lp-1:0]      dec_cnt;
    logic [els_p*width_p-1:0] data_flat;

    // Per-entry data storage. Not reset; writes are dropped while reset is held.
    for (genvar gi = 0; gi < els_p; gi++) begin : g_entry
        logic [width_p-1:0] data_q;

        // Load this entry when its write select is set.
        always_ff @(posedge clk_i) begin
            if (reset_n_i && w_v_i[gi]) begin
                data_q <= w_data_i;
            end
        end

        assign data_flat[gi*width_p +: width_p] = data_q;
    end

    // Write sets valid, invalidate clears it; a write beats a clear on the same entry.
    always_comb begin
        valid_d = (valid_q & ~clr_v_i) | w_v_i;
    end

    // Count changes: newly filled entries add, cleared-and-not-rewritten entries subtract.
    always_comb begin
        inc_cnt = '0;
        dec_cnt = '0;
        for (int i = 0; i < els_p; i++) begin
            inc_cnt = inc_cnt + cnt_w_lp'(w_v_i[i] & ~valid_q[i]);
            dec_cnt = dec_cnt + cnt_w_lp'(clr_v_i[i] & valid_q[i] & ~w_v_i[i]);
        end
        count_d = count_q + inc_cnt - dec_cnt;
    end

    // Valid vector and occupancy count state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign count_o = count_q;
    assign full_o  = (count_q == cnt_w_lp'(els_p));
    assign empty_o = (count_q == '0);

    // Independent read ports; every port sees the same pre-edge storage and valid vector.
    for (genvar gi = 0; gi < read_ports_p; gi++) begin : g_port
        bsg_mem_one_hot_read_port #(
            .width_p        (width_p),
            .els_p          (els_p),
            .sync_read_p    (sync_read_p),
            .write_bypass_p (write_bypass_p)
        ) u_port (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .data_i    (data_flat),
            .valid_i   (valid_q),
            .r_v_i     (r_v_i[gi*els_p +: els_p]),
            .w_v_i     (w_v_i),
            .w_data_i  (w_data_i),
            .r_data_o  (r_data_o[gi*width_p +: width_p]),
            .r_valid_o (r_valid_o[gi])
        );
    end

`ifndef SYNTHESIS
    // Select vectors must be one- or zero-hot; checked away from the active edge.
    a_w_v_onehot0: assert property (@(negedge clk_i) disable iff (!reset_n_i) $onehot0(w_v_i));

    for (genvar gi = 0; gi < read_ports_p; gi++) begin : g_port_chk
        a_r_v_onehot0: assert property (@(negedge clk_i) disable iff (!reset_n_i)
                                        $onehot0(r_v_i[gi*els_p +: els_p]));
    end
`endif

endmodule
